// File: rtl/echo_tof_detector.sv
// Echo time-of-flight detector: times from a transmitter burst to the first qualified echo,
// blanking transducer ringing, and reports the echo time and peak magnitude or a timeout.
module echo_tof_detector #(
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned BLANK_CYCLES = 50000,
   parameter int unsigned MAX_CYCLES   = 700000,
   parameter int unsigned THRESHOLD    = 2048,
   parameter int unsigned HOLD_SAMPLES = 4
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic              ON,
   input  logic              burstStart,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic              busy,
   output logic              tof_valid,
   output logic              timeout,
   output logic [CNT_W-1:0]  tof_count,
   output logic [DATA_W-1:0] peak
);

   localparam int unsigned RUN_W = $clog2(HOLD_SAMPLES + 1);

   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
   localparam logic [DATA_W-1:0] THR        = DATA_W'(THRESHOLD);
   localparam logic [RUN_W-1:0]  HOLD       = RUN_W'(HOLD_SAMPLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_LISTEN
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  timer_q;
   logic [CNT_W-1:0]  cand_q;
   logic [RUN_W-1:0]  run_q;
   logic [DATA_W-1:0] trk_q;
   logic              busy_q;
   logic              tof_valid_q;
   logic              timeout_q;
   logic [CNT_W-1:0]  tof_count_q;
   logic [DATA_W-1:0] peak_q;

   logic              qualify;
   logic [RUN_W-1:0]  run_d;
   logic [CNT_W-1:0]  cand_d;
   logic [DATA_W-1:0] trk_d;
   logic              hit;

   // Candidate and peak include the current sample so a detection on this edge
   // reports the run start and the final maximum without an extra cycle.
   always_comb begin
      qualify = sample_valid && (sample >= THR);
      run_d   = run_q;
      cand_d  = cand_q;
      trk_d   = trk_q;
      if (sample_valid) begin
         if (sample > trk_q) begin
            trk_d = sample;
         end
         if (qualify) begin
            run_d = run_q + 1'b1;
            if (run_q == '0) begin
               cand_d = timer_q;
            end
         end else begin
            run_d = '0;
         end
      end
      hit = (state_q == S_LISTEN) && qualify && (run_d == HOLD);
   end

   always_ff @(posedge SYS_CLK) begin
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (RST) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         cand_q      <= '0;
         run_q       <= '0;
         trk_q       <= '0;
         busy_q      <= 1'b0;
         tof_count_q <= '0;
         peak_q      <= '0;
      end else if (!ON) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
      end else if (burstStart) begin
         // A burst in any state (re)starts the measurement from the top of blanking.
         state_q <= S_BLANK;
         timer_q <= '0;
         cand_q  <= '0;
         run_q   <= '0;
         trk_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            S_BLANK: begin
               timer_q <= timer_q + 1'b1;
               if (timer_q >= BLANK_LAST) begin
                  state_q <= S_LISTEN;
               end
            end
            S_LISTEN: begin
               timer_q <= timer_q + 1'b1;
               run_q   <= run_d;
               cand_q  <= cand_d;
               trk_q   <= trk_d;
               if (hit) begin
                  tof_valid_q <= 1'b1;
                  tof_count_q <= cand_d;
                  peak_q      <= trk_d;
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
               end else if (timer_q >= MAX_LAST) begin
                  timeout_q <= 1'b1;
                  peak_q    <= trk_d;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign tof_valid = tof_valid_q;
   assign timeout   = timeout_q;
   assign tof_count = tof_count_q;
   assign peak      = peak_q;

endmodule
